// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: valid/ready handshake with a 2-entry skid buffer, sync flush, optional bubble zeroing.
// Define PIPE_STAGE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_buf #(
    parameter int WIDTH       = 137,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_inFire;
    logic             w_outFire;

    // Handshake outputs decode registered state only, so out_ready never reaches in_ready combinationally.
    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = (r_state != ST_FULL);
    assign out_data  = r_main;

    assign w_inFire  = in_valid & in_ready;
    assign w_outFire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            if (ZERO_BUBBLE != 0) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_inFire) begin
                        r_main  <= in_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_inFire && w_outFire) begin
                        r_main <= in_data;
                    end else if (w_inFire) begin
                        r_skid  <= in_data;
                        r_state <= ST_FULL;
                    end else if (w_outFire) begin
                        r_state <= ST_EMPTY;
                        if (ZERO_BUBBLE != 0) begin
                            r_main <= '0;
                        end
                    end
                end
                ST_FULL: begin
                    if (w_outFire) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] r_stallCnt;

    // Counts edges where a held bundle is refused downstream; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stallCnt <= '0;
        end else if (out_valid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: queue of accepted bundles compared against the output each cycle.
// Also exercises a ZERO_BUBBLE=0 instance and, when PIPE_STAGE_STALL_CNT_EN is defined, the stall counter.
module tb_pipe_stage_buf;

    localparam int W  = 137;
    localparam int ZW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    logic          zInValid = 1'b0;
    logic          zOutReady = 1'b0;
    logic [ZW-1:0] zInData = '0;
    logic          zInReady;
    logic          zOutValid;
    logic [ZW-1:0] zOutData;

    int errors = 0;
    int checks = 0;
    int expCnt = 0;
    logic [W-1:0] sbq[$];

    pipe_stage_buf #(.WIDTH(W), .ZERO_BUBBLE(1), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    pipe_stage_buf #(.WIDTH(ZW), .ZERO_BUBBLE(0), .CNT_W(CW)) dutNoZero (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(zInValid),
        .in_ready(zInReady),
        .in_data(zInData),
        .out_valid(zOutValid),
        .out_ready(zOutReady),
        .out_data(zOutData)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt()
`endif
    );

    // Expected {in_ready, out_valid, out_data} derived from scoreboard occupancy.
    function automatic logic [W+1:0] expState();
        logic [W-1:0] d;
        d = (sbq.size() != 0) ? sbq[0] : '0;
        return {(sbq.size() != 2), (sbq.size() != 0), d};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic rst);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
    endtask

    // Applies this cycle's handshake to the model, then lets the edge happen.
    task automatic commit();
        logic inF, outF;
        inF  = in_valid && (sbq.size() != 2);
        outF = (sbq.size() != 0) && out_ready;
        if (!reset) expCnt = 0;
        else if ((sbq.size() != 0) && !out_ready && (expCnt != (1 << CW) - 1)) expCnt++;
        if (!reset || flush) begin
            sbq.delete();
        end else begin
            if (outF) sbq.delete(0);
            if (inF) sbq.push_back(in_data);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, W'(99), 1'b0, 1'b0, 1'b0);
        commit();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        commit();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({in_ready, out_valid, out_data} !== expState()) begin
            errors++;
            $display("[TB] FAIL reset: got %h want %h", {in_ready, out_valid, out_data}, expState());
        end
        commit();
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 10; i++) begin
            drive((i <= 8), W'(i), 1'b1, 1'b0, 1'b1);
            checks++;
            if ({in_ready, out_valid, out_data} !== expState()) begin
                errors++;
                $display("[TB] FAIL stream cyc%0d: got %h want %h", i, {in_ready, out_valid, out_data}, expState());
            end
            commit();
        end
    endtask

    task automatic test_backpressure();
        logic          v[7]    = '{1, 1, 1, 1, 1, 0, 0};
        logic [7:0]    d[7]    = '{8'hA, 8'hB, 8'hC, 8'hC, 8'hC, 8'h0, 8'h0};
        logic          ordy[7] = '{1, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            drive(v[i], W'(d[i]), ordy[i], 1'b0, 1'b1);
            checks++;
            if ({in_ready, out_valid, out_data} !== expState()) begin
                errors++;
                $display("[TB] FAIL backpressure cyc%0d: got %h want %h", i, {in_ready, out_valid, out_data}, expState());
            end
            commit();
        end
    endtask

    task automatic test_flush();
        logic          v[8]    = '{1, 1, 1, 0, 1, 1, 0, 0};
        logic [7:0]    d[8]    = '{8'h11, 8'h12, 8'hD, 8'h0, 8'h21, 8'hD, 8'h0, 8'h0};
        logic          ordy[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        logic          fl[8]   = '{0, 0, 1, 0, 0, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drive(v[i], W'(d[i]), ordy[i], fl[i], 1'b1);
            checks++;
            if ({in_ready, out_valid, out_data} !== expState()) begin
                errors++;
                $display("[TB] FAIL flush cyc%0d: got %h want %h", i, {in_ready, out_valid, out_data}, expState());
            end
            commit();
        end
    endtask

    task automatic test_mid_reset();
        logic          v[4]    = '{1, 1, 1, 0};
        logic [7:0]    d[4]    = '{8'h31, 8'h32, 8'h33, 8'h0};
        logic          ordy[4] = '{0, 0, 1, 1};
        logic          rst[4]  = '{1, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            drive(v[i], W'(d[i]), ordy[i], 1'b0, rst[i]);
            checks++;
            if ({in_ready, out_valid, out_data} !== expState()) begin
                errors++;
                $display("[TB] FAIL midreset cyc%0d: got %h want %h", i, {in_ready, out_valid, out_data}, expState());
            end
            commit();
        end
    endtask

    task automatic test_zero_bubble_off();
        logic          zv[4]   = '{1, 0, 0, 0};
        logic [ZW:0]   want[4] = '{{1'b0, 8'h00}, {1'b1, 8'h55}, {1'b0, 8'h55}, {1'b0, 8'h55}};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
            zInValid  = zv[i];
            zInData   = 8'h55;
            zOutReady = 1'b1;
            #1;
            checks++;
            if ({zOutValid, zOutData} !== want[i] || zInReady !== 1'b1) begin
                errors++;
                $display("[TB] FAIL nozero cyc%0d: got v/d %h rdy %b want %h rdy 1", i, {zOutValid, zOutData}, zInReady, want[i]);
            end
            commit();
        end
        zInValid = 1'b0;
    endtask

    task automatic test_random();
        logic         v, o, f, holdV;
        logic [W-1:0] d, holdD;
        holdV = 1'b0;
        holdD = '0;
        for (int i = 0; i < 200; i++) begin
            if (holdV) begin
                v = 1'b1;
                d = holdD;
            end else begin
                v = 1'($urandom_range(0, 1));
                d = W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            end
            o = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 31) == 0);
            drive(v, d, o, f, 1'b1);
            checks++;
            if ({in_ready, out_valid, out_data} !== expState()) begin
                errors++;
                $display("[TB] FAIL random cyc%0d: got %h want %h", i, {in_ready, out_valid, out_data}, expState());
            end
            holdV = v && (sbq.size() == 2) && !f;
            holdD = d;
            commit();
        end
    endtask

`ifdef PIPE_STAGE_STALL_CNT_EN
    task automatic test_stall_cnt();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        commit();
        drive(1'b1, W'(8'h77), 1'b0, 1'b0, 1'b1);
        checks++;
        if (stall_cnt !== CW'(0)) begin
            errors++;
            $display("[TB] FAIL stallcnt_reset: got %0d want 0", stall_cnt);
        end
        commit();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (stall_cnt !== CW'(expCnt) || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stallcnt cyc%0d: got %0d valid %b want %0d valid 1", i, stall_cnt, out_valid, expCnt);
            end
            commit();
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("[TB] FAIL stallcnt_sat: got %0d want 15", stall_cnt);
        end
        commit();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stallcnt_flush: got %0d valid %b want 15 valid 0", stall_cnt, out_valid);
        end
        commit();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_mid_reset();
        test_zero_bubble_off();
        test_random();
`ifdef PIPE_STAGE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
